// File: rtl/serializer_pkg.sv
// Shared types and helpers for the multilane serializer: FSM state encoding,
// default idle symbol and the counter-width function.
package serializer_pkg;

    typedef enum logic {
        TRAIN = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam logic [7:0] DEFAULT_IDLE_SYM = 8'hBC;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/multilane_serializer_if.sv
// Lane-side bus of the multilane serializer: FIFO heads and flags in,
// pops and serial streams out.
interface multilane_serializer_if #(
    parameter int LANES     = 2,
    parameter int DATA_SIZE = 8
);
    logic [LANES*DATA_SIZE-1:0] in_data;
    logic [LANES-1:0]           fifo_empty;
    logic [LANES-1:0]           fifo_almost_empty;
    logic [LANES-1:0]           up_almostfull;
    logic [LANES-1:0]           pop;
    logic [LANES-1:0]           out_serial;
    logic [LANES-1:0]           out_valid;
    logic                       word_sync;

    // master is the FIFO/downstream side, slave is the serializer
    modport master (
        output in_data, fifo_empty, fifo_almost_empty, up_almostfull,
        input  pop, out_serial, out_valid, word_sync
    );

    modport slave (
        input  in_data, fifo_empty, fifo_almost_empty, up_almostfull,
        output pop, out_serial, out_valid, word_sync
    );
endinterface

// File: rtl/serializer_lane.sv
// One serial lane: pop decode, parallel-load shift register and data marker.
// SERIALIZER_IDLE_INSERT_EN selects IDLE_SYM (defined) or zeros (undefined) as filler.
module serializer_lane #(
    parameter int                   DATA_SIZE = 8,
    parameter logic [DATA_SIZE-1:0] IDLE_SYM  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 run,
    input  logic [DATA_SIZE-1:0] data,
    input  logic                 fifo_empty,
    input  logic                 fifo_almost_empty,
    input  logic                 up_almostfull,
    output logic                 pop,
    output logic                 out_serial,
    output logic                 out_valid
);
`ifdef SERIALIZER_IDLE_INSERT_EN
    localparam logic [DATA_SIZE-1:0] FILL_WORD = IDLE_SYM;
`else
    // zero filler; IDLE_SYM stays referenced so both builds share one parameter list
    localparam logic [DATA_SIZE-1:0] FILL_WORD = IDLE_SYM & {DATA_SIZE{1'b0}};
`endif

    logic                 elig;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic                 valid_q, valid_d;

    always_comb begin
        elig    = ~fifo_empty & ~fifo_almost_empty & ~up_almostfull;
        pop     = load & run & elig & ~reset;
        shift_d = shift_q << 1;
        valid_d = valid_q;
        if (load) begin
            shift_d = pop ? data : FILL_WORD;
            valid_d = pop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    assign out_serial = shift_q[DATA_SIZE-1];
    assign out_valid  = valid_q;
endmodule

// File: rtl/multilane_serializer.sv
// N-lane parallel-to-serial converter on a single bit clock with training phase.
// Optional macro SERIALIZER_IDLE_INSERT_EN selects IDLE_SYM filler on stalled lanes.
module multilane_serializer
    import serializer_pkg::*;
#(
    parameter int                   DATA_SIZE   = 8,
    parameter int                   LANES       = 2,
    parameter int                   TRAIN_WORDS = 4,
    parameter logic [DATA_SIZE-1:0] IDLE_SYM    = DATA_SIZE'(DEFAULT_IDLE_SYM)
) (
    input logic                    clk,
    input logic                    reset,
    multilane_serializer_if.slave  bus
);
    localparam int             CW         = (clog2(DATA_SIZE) > 0) ? clog2(DATA_SIZE) : 1;
    localparam logic [CW-1:0]  CNT_LAST   = CW'(DATA_SIZE - 1);
    localparam logic [7:0]     TRAIN_LAST = 8'(TRAIN_WORDS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    state_e        state_q, state_d;
    logic [7:0]    train_q, train_d;
    logic          loaded_q, loaded_d;
    logic          boundary, run, word_sync;
    logic [LANES-1:0] pop_w, ser_w, val_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            state_q  <= TRAIN;
            train_q  <= '0;
            loaded_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            train_q  <= train_d;
            loaded_q <= loaded_d;
        end
    end

    always_comb begin
        cnt_d    = boundary ? '0 : cnt_q + CW'(1);
        state_d  = state_q;
        train_d  = train_q;
        loaded_d = loaded_q | boundary;
        if (boundary && state_q == TRAIN) begin
            train_d = train_q + 8'd1;
            if (train_q == TRAIN_LAST) state_d = RUN;
        end
    end

    // the first boundary marks the end of the cleared post-reset word
    always_comb begin
        boundary  = (cnt_q == CNT_LAST);
        run       = (state_q == RUN);
        word_sync = (cnt_q == '0) & loaded_q;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        serializer_lane #(
            .DATA_SIZE (DATA_SIZE),
            .IDLE_SYM  (IDLE_SYM)
        ) u_lane (
            .clk               (clk),
            .reset             (reset),
            .load              (boundary),
            .run               (run),
            .data              (bus.in_data[i*DATA_SIZE +: DATA_SIZE]),
            .fifo_empty        (bus.fifo_empty[i]),
            .fifo_almost_empty (bus.fifo_almost_empty[i]),
            .up_almostfull     (bus.up_almostfull[i]),
            .pop               (pop_w[i]),
            .out_serial        (ser_w[i]),
            .out_valid         (val_w[i])
        );
    end

    assign bus.pop        = pop_w;
    assign bus.out_serial = ser_w;
    assign bus.out_valid  = val_w;
    assign bus.word_sync  = word_sync;
endmodule

// File: tb/tb_multilane_serializer.sv
// Scoreboard bench for multilane_serializer: randomized FIFO flags and data,
// expected words predicted per boundary, a monitor reassembles serial words.
module tb_multilane_serializer;
    localparam int DS = 8;
    localparam int LN = 2;
    localparam int TW = 4;
`ifdef SERIALIZER_IDLE_INSERT_EN
    localparam logic [DS-1:0] FILL_EXP = 8'hBC;
`else
    localparam logic [DS-1:0] FILL_EXP = 8'h00;
`endif

    typedef struct packed {
        logic [LN-1:0]    pop;
        logic [LN-1:0]    valid;
        logic [LN*DS-1:0] words;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   c = 0;
    bit   stop = 1'b0;
    rec_t sb[$];

    multilane_serializer_if #(.LANES(LN), .DATA_SIZE(DS)) bus();

    multilane_serializer #(
        .DATA_SIZE   (DS),
        .LANES       (LN),
        .TRAIN_WORDS (TW),
        .IDLE_SYM    (8'hBC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // monitor state
    bit            collecting = 1'b0;
    int            bitpos = 0;
    logic [LN-1:0] prev_pop = '0;
    rec_t          cur;
    logic [DS-1:0] acc [LN];
    logic [DS-1:0] vacc [LN];

    always @(negedge clk) begin
        if (stop) begin
        end else if (reset) begin
            collecting = 1'b0;
            bitpos     = 0;
            prev_pop   = '0;
        end else begin
            if (bus.pop != '0) begin
                checks++;
                if (!(collecting && bitpos == DS-1)) begin
                    errors++;
                    $display("FAIL pop_timing: pop=%b at bit position %0d, required only at last bit", bus.pop, bitpos);
                end
            end
            if (bus.word_sync) begin
                if (collecting) begin
                    checks++; errors++;
                    $display("FAIL sync_early: word_sync=1 at bit %0d, required 0", bitpos);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    collecting = 1'b0;
                    $display("FAIL sb_empty: word_sync=1 with no expected word, required 0");
                end else begin
                    cur = sb.pop_front();
                    collecting = 1'b1;
                    bitpos = 0;
                    if (prev_pop !== cur.pop) begin
                        errors++;
                        $display("FAIL pop_value: got %b want %b", prev_pop, cur.pop);
                    end
                end
            end else if (!collecting) begin
                checks++;
                if (bus.out_serial !== '0 || bus.out_valid !== '0) begin
                    errors++;
                    $display("FAIL idle_zero: serial=%b valid=%b want 0/0", bus.out_serial, bus.out_valid);
                end
            end
            if (collecting) begin
                for (int l = 0; l < LN; l++) begin
                    acc[l]  = {acc[l][DS-2:0], bus.out_serial[l]};
                    vacc[l] = {vacc[l][DS-2:0], bus.out_valid[l]};
                end
                bitpos++;
                if (bitpos == DS) begin
                    for (int l = 0; l < LN; l++) begin
                        checks += 2;
                        if (acc[l] !== cur.words[l*DS +: DS]) begin
                            errors++;
                            $display("FAIL word lane%0d: got %h want %h", l, acc[l], cur.words[l*DS +: DS]);
                        end
                        if (vacc[l] !== {DS{cur.valid[l]}}) begin
                            errors++;
                            $display("FAIL valid lane%0d: got %b want %b", l, vacc[l], {DS{cur.valid[l]}});
                        end
                    end
                    collecting = 1'b0;
                end
            end
            prev_pop = bus.pop;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        #1;
        checks++;
        if (bus.pop !== '0 || bus.out_serial !== '0 || bus.out_valid !== '0 || bus.word_sync !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: pop=%b ser=%b val=%b sync=%b want all 0",
                     bus.pop, bus.out_serial, bus.out_valid, bus.word_sync);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        c = 0;
    endtask

    // one bit-cycle of stimulus; at boundary cycles the expected word is predicted
    task automatic drive_cycle(input int pct);
        int            k;
        bit            bnd;
        rec_t          r;
        logic [DS-1:0] d [LN];
        logic [LN-1:0] fe, fae, uaf;
        k   = c / DS;
        bnd = (c % DS) == DS-1;
        for (int l = 0; l < LN; l++) begin
            d[l]   = DS'($urandom);
            fe[l]  = ($urandom_range(0, 99) < pct);
            fae[l] = ($urandom_range(0, 99) < pct);
            uaf[l] = ($urandom_range(0, 99) < pct);
        end
        if (bnd && k == TW) begin
            d[0] = 8'hA5; d[1] = 8'h3C;
            fe = '0; fae = '0; uaf = '0;
        end else if (bnd && k == TW + 1) begin
            fe = '0; fae = '0; uaf = 2'b10;
        end
        for (int l = 0; l < LN; l++) bus.in_data[l*DS +: DS] = d[l];
        bus.fifo_empty        = fe;
        bus.fifo_almost_empty = fae;
        bus.up_almostfull     = uaf;
        if (bnd) begin
            r = '0;
            for (int l = 0; l < LN; l++) begin
                if (k >= TW && !fe[l] && !fae[l] && !uaf[l]) begin
                    r.pop[l] = 1'b1;
                    r.valid[l] = 1'b1;
                    r.words[l*DS +: DS] = d[l];
                end else begin
                    r.words[l*DS +: DS] = FILL_EXP;
                end
            end
            sb.push_back(r);
        end
        @(posedge clk);
        #1;
        c++;
    endtask

    initial begin
        bus.in_data           = '0;
        bus.fifo_empty        = '0;
        bus.fifo_almost_empty = '0;
        bus.up_almostfull     = '0;
        @(posedge clk);
        #1;
        do_reset();
        repeat (120) drive_cycle(0);
        repeat (100) drive_cycle(20);
        while ((c % DS) != 4) drive_cycle(20);
        do_reset();
        repeat (150) drive_cycle(35);
        repeat (60) drive_cycle(70);
        for (int i = 0; i < 4*DS && !(sb.size() == 0 && !collecting); i++) @(posedge clk);
        checks++;
        if (sb.size() != 0 || collecting) begin
            errors++;
            $display("FAIL drain: %0d expected words outstanding, want 0", sb.size());
        end
        stop = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
